// File: rtl/sram_param_pkg.sv
// Shared types and constants for the parameterised byte-enable SRAM.
package sram_param_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/sram_param_be_if.sv
// Access bus of the byte-enable SRAM: request fields from the master, read response back.
interface sram_param_be_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) ();

  logic                  en;
  logic                  wren;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   be;
  logic [DATA_W-1:0]     q;
  logic                  q_valid;
  logic                  init_busy;

  modport master (
    output en, wren, addr, wdata, be,
    input  q, q_valid, init_busy
  );

  modport slave (
    input  en, wren, addr, wdata, be,
    output q, q_valid, init_busy
  );

endinterface

// File: rtl/sram_rd_pipe.sv
// RD_LAT-deep read-data/valid pipeline; the last stage is the registered q/q_valid output.
module sram_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] q,
  output logic              q_valid
);

  logic [DATA_W-1:0] data_r [RD_LAT];
  logic [RD_LAT-1:0] valid_r;

  // Data only advances alongside a valid token, so the last stage holds q between accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        data_r[i] <= '0;
      end
    end else begin
      valid_r[0] <= in_valid;
      if (in_valid) begin
        data_r[0] <= in_data;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        valid_r[i] <= valid_r[i-1];
        if (valid_r[i-1]) begin
          data_r[i] <= data_r[i-1];
        end
      end
    end
  end

  assign q       = data_r[RD_LAT-1];
  assign q_valid = valid_r[RD_LAT-1];

endmodule

// File: rtl/sram_param_be.sv
// Single-port SRAM with byte-lane write enables, self-clearing after reset,
// configurable read latency and read-during-write result.
module sram_param_be
  import sram_param_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = RDW_OLD
) (
  input  logic           clk,
  input  logic           rst,
  sram_param_be_if.slave bus
);

  localparam int BE_W = DATA_W / 8;

  state_e            state_r;
  logic [ADDR_W-1:0] cnt_r;
  logic              init_busy_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              access_s;
  logic              in_range_s;
  logic              clearing_s;
  logic [BE_W-1:0]   lane_we_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [DATA_W-1:0] wr_data_s;
  logic [DATA_W-1:0] rd_old_s;
  logic [DATA_W-1:0] rd_new_s;
  logic [DATA_W-1:0] rd_word_s;

  // Access qualification, write-port steering and the read-during-write result.
  always_comb begin
    in_range_s = ({1'b0, bus.addr} < (ADDR_W + 1)'(DEPTH));
    access_s   = bus.en && (state_r == ST_READY) && !rst;
    clearing_s = (state_r == ST_INIT) && !rst;

    if (clearing_s) begin
      wr_addr_s = cnt_r;
      wr_data_s = '0;
      lane_we_s = '1;
    end else if (access_s && bus.wren && in_range_s) begin
      wr_addr_s = bus.addr;
      wr_data_s = bus.wdata;
      lane_we_s = bus.be;
    end else begin
      wr_addr_s = bus.addr;
      wr_data_s = bus.wdata;
      lane_we_s = '0;
    end

    rd_old_s = in_range_s ? mem_r[bus.addr] : '0;
    for (int i = 0; i < BE_W; i++) begin
      rd_new_s[8*i +: 8] = bus.be[i] ? bus.wdata[8*i +: 8] : rd_old_s[8*i +: 8];
    end

    // Out-of-range accesses always answer zero, whatever the write data.
    if (!in_range_s) begin
      rd_word_s = '0;
    end else if ((RDW_MODE == RDW_NEW) && bus.wren) begin
      rd_word_s = rd_new_s;
    end else begin
      rd_word_s = rd_old_s;
    end
  end

  // Memory array: one write port, per-lane enables, no reset (the clear sequence defines contents).
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (lane_we_s[i]) begin
        mem_r[wr_addr_s][8*i +: 8] <= wr_data_s[8*i +: 8];
      end
    end
  end

  // Clear/ready state machine with registered busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_INIT;
      cnt_r       <= '0;
      init_busy_r <= 1'b1;
    end else begin
      case (state_r)
        ST_INIT: begin
          if (cnt_r == ADDR_W'(DEPTH - 1)) begin
            state_r     <= ST_READY;
            cnt_r       <= '0;
            init_busy_r <= 1'b0;
          end else begin
            cnt_r       <= cnt_r + ADDR_W'(1);
          end
        end
        ST_READY: begin
          state_r     <= ST_READY;
          init_busy_r <= 1'b0;
        end
        default: begin
          state_r     <= ST_INIT;
          cnt_r       <= '0;
          init_busy_r <= 1'b1;
        end
      endcase
    end
  end

  sram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (access_s),
    .in_data  (rd_word_s),
    .q        (bus.q),
    .q_valid  (bus.q_valid)
  );

  assign bus.init_busy = init_busy_r;

endmodule

// File: tb/tb_sram_param_be.sv
// Scoreboard bench: four configurations (default, new-data RDW, 2-cycle latency,
// 1000-word depth) driven with the same directed accesses.
module tb_sram_param_be;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  exp_t sb0[$], sb1[$], sb2[$], sb3[$];
  exp_t e0, e1, e2, e3;

  bit count_en = 1'b0;
  int b0, b1, b2, b3;

  sram_param_be_if #(.DATA_W(32), .ADDR_W(10)) if0 ();
  sram_param_be_if #(.DATA_W(32), .ADDR_W(10)) if1 ();
  sram_param_be_if #(.DATA_W(32), .ADDR_W(10)) if2 ();
  sram_param_be_if #(.DATA_W(32), .ADDR_W(10)) if3 ();

  sram_param_be #(.DATA_W(32), .DEPTH(1024), .RD_LAT(1), .RDW_MODE(0))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  sram_param_be #(.DATA_W(32), .DEPTH(1024), .RD_LAT(1), .RDW_MODE(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  sram_param_be #(.DATA_W(32), .DEPTH(1024), .RD_LAT(2), .RDW_MODE(0))
    dut2 (.clk(clk), .rst(rst), .bus(if2));
  sram_param_be #(.DATA_W(32), .DEPTH(1000), .RD_LAT(1), .RDW_MODE(0))
    dut3 (.clk(clk), .rst(rst), .bus(if3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got q_valid=1 expected no response", name);
  endtask

  always @(negedge clk) if (if0.q_valid === 1'b1) begin
    if (sb0.size() == 0) unexpected("dut0_qvalid");
    else begin
      e0 = sb0.pop_front();
      chk("dut0_q", if0.q, e0.data);
      chk("dut0_lat", 32'(cyc), 32'(e0.due));
    end
  end

  always @(negedge clk) if (if1.q_valid === 1'b1) begin
    if (sb1.size() == 0) unexpected("dut1_qvalid");
    else begin
      e1 = sb1.pop_front();
      chk("dut1_q", if1.q, e1.data);
      chk("dut1_lat", 32'(cyc), 32'(e1.due));
    end
  end

  always @(negedge clk) if (if2.q_valid === 1'b1) begin
    if (sb2.size() == 0) unexpected("dut2_qvalid");
    else begin
      e2 = sb2.pop_front();
      chk("dut2_q", if2.q, e2.data);
      chk("dut2_lat", 32'(cyc), 32'(e2.due));
    end
  end

  always @(negedge clk) if (if3.q_valid === 1'b1) begin
    if (sb3.size() == 0) unexpected("dut3_qvalid");
    else begin
      e3 = sb3.pop_front();
      chk("dut3_q", if3.q, e3.data);
      chk("dut3_lat", 32'(cyc), 32'(e3.due));
    end
  end

  always @(negedge clk) if (count_en) begin
    b0 += int'(if0.init_busy);
    b1 += int'(if1.init_busy);
    b2 += int'(if2.init_busy);
    b3 += int'(if3.init_busy);
  end

  task automatic drive(input logic en, input logic w, input logic [9:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    if0.en = en; if0.wren = w; if0.addr = a; if0.wdata = d; if0.be = b;
    if1.en = en; if1.wren = w; if1.addr = a; if1.wdata = d; if1.be = b;
    if2.en = en; if2.wren = w; if2.addr = a; if2.wdata = d; if2.be = b;
    if3.en = en; if3.wren = w; if3.addr = a; if3.wdata = d; if3.be = b;
  endtask

  // Issue one access (called at posedge+1) and push each DUT's expected response.
  task automatic acc(input logic w, input logic [9:0] a, input logic [31:0] d,
                     input logic [3:0] b, input logic [31:0] x0, input logic [31:0] x1,
                     input logic [31:0] x2, input logic [31:0] x3, input bit push2 = 1'b1);
    drive(1'b1, w, a, d, b);
    sb0.push_back('{x0, cyc + 1});
    sb1.push_back('{x1, cyc + 1});
    if (push2) sb2.push_back('{x2, cyc + 2});
    sb3.push_back('{x3, cyc + 1});
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic start_busy_count();
    b0 = 0; b1 = 0; b2 = 0; b3 = 0;
    count_en = 1'b1;
  endtask

  task automatic check_busy_count(input string tag);
    count_en = 1'b0;
    chk({tag, "_busy0"}, 32'(b0), 32'd1024);
    chk({tag, "_busy1"}, 32'(b1), 32'd1024);
    chk({tag, "_busy2"}, 32'(b2), 32'd1024);
    chk({tag, "_busy3"}, 32'(b3), 32'd1000);
  endtask

  logic [31:0] old_v;

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_q0", if0.q, 32'h0);        chk("rst_qv0", 32'(if0.q_valid), 32'd0);
    chk("rst_busy0", 32'(if0.init_busy), 32'd1);
    chk("rst_q2", if2.q, 32'h0);        chk("rst_qv2", 32'(if2.q_valid), 32'd0);
    chk("rst_busy2", 32'(if2.init_busy), 32'd1);
    chk("rst_busy3", 32'(if3.init_busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    start_busy_count();

    // Accesses during the clear must be ignored (no response, no memory update).
    drive(1'b1, 1'b1, 10'd6, 32'hFFFF_FFFF, 4'hF);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 10'd6, 32'h0, 4'h0);
    @(posedge clk); #1;
    idle(1100);
    check_busy_count("init");

    acc(1'b0, 10'h3FF, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    acc(1'b0, 10'd6,   32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    acc(1'b1, 10'd5, 32'hAABB_CCDD, 4'hF, 32'h0, 32'hAABB_CCDD, 32'h0, 32'h0);
    acc(1'b1, 10'd5, 32'h1122_3344, 4'b0101,
        32'hAABB_CCDD, 32'hAA22_CC44, 32'hAABB_CCDD, 32'hAABB_CCDD);
    acc(1'b0, 10'd5, 32'h0, 4'h0, 32'hAA22_CC44, 32'hAA22_CC44, 32'hAA22_CC44, 32'hAA22_CC44);
    acc(1'b1, 10'd7, 32'h1, 4'hF, 32'h0, 32'h1, 32'h0, 32'h0);
    acc(1'b1, 10'd7, 32'h2, 4'hF, 32'h1, 32'h2, 32'h1, 32'h1);
    acc(1'b0, 10'd7, 32'h0, 4'h0, 32'h2, 32'h2, 32'h2, 32'h2);
    acc(1'b1, 10'd7, 32'hFFFF_FFFF, 4'h0, 32'h2, 32'h2, 32'h2, 32'h2);
    acc(1'b0, 10'd7, 32'h0, 4'h0, 32'h2, 32'h2, 32'h2, 32'h2);
    acc(1'b1, 10'd1010, 32'hFFFF_FFFF, 4'hF, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0);
    acc(1'b0, 10'd1010, 32'h0, 4'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    acc(1'b0, 10'd999, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    acc(1'b0, 10'd0,   32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);

    // Back-to-back writes then back-to-back reads of addresses 0..9.
    for (int i = 0; i < 10; i++) begin
      old_v = (i == 5) ? 32'hAA22_CC44 : ((i == 7) ? 32'h2 : 32'h0);
      acc(1'b1, 10'(i), 32'h100 + 32'(i), 4'hF, old_v, 32'h100 + 32'(i), old_v, old_v);
    end
    for (int i = 0; i < 10; i++) begin
      acc(1'b0, 10'(i), 32'h0, 4'h0, 32'h100 + 32'(i), 32'h100 + 32'(i),
          32'h100 + 32'(i), 32'h100 + 32'(i));
    end
    idle(3);
    @(negedge clk);
    chk("hold_q0", if0.q, 32'h109);
    chk("hold_qv0", 32'(if0.q_valid), 32'd0);
    chk("hold_q2", if2.q, 32'h109);
    @(posedge clk); #1;

    // Reset while the 2-cycle-latency read is still in flight: that response must vanish.
    acc(1'b0, 10'd5, 32'h0, 4'h0, 32'h105, 32'h105, 32'h105, 32'h105, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(500);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start_busy_count();
    idle(1100);
    check_busy_count("rerst");

    acc(1'b0, 10'd5, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    acc(1'b0, 10'd1010, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    idle(5);
    chk("drain0", 32'(sb0.size()), 32'd0);
    chk("drain1", 32'(sb1.size()), 32'd0);
    chk("drain2", 32'(sb2.size()), 32'd0);
    chk("drain3", 32'(sb3.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
